// File: rtl/serial_tx_block.sv
// Idle-high, LSB-first serial transmitter: start bit, 5..8 data bits, optional
// even parity (enabled by defining SERIAL_TX_PARITY_EN), stop bit.
module serial_tx_block #(
  parameter int BIT_PERIOD_BITS = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_start,
  input  logic [7:0]                 tx_data,
  input  logic [3:0]                 data_size,
  input  logic [BIT_PERIOD_BITS-1:0] bit_period,
  output logic                       serial_out,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [BIT_PERIOD_BITS-1:0] ONE = {{(BIT_PERIOD_BITS-1){1'b0}}, 1'b1};

  logic [2:0]                 r_state;
  logic [7:0]                 r_data;
  logic [2:0]                 r_last;
  logic [BIT_PERIOD_BITS-1:0] r_period;
  logic [BIT_PERIOD_BITS-1:0] r_tcnt;
  logic [2:0]                 r_idx;

  logic [2:0]                 w_next_state;
  logic [BIT_PERIOD_BITS-1:0] w_next_tcnt;
  logic [2:0]                 w_next_idx;
  logic                       w_roll;
  logic [2:0]                 w_last_cap;
  logic [BIT_PERIOD_BITS-1:0] w_period_cap;
  logic                       w_line;
  logic                       w_accept;

  assign w_accept     = (r_state == IDLE) && tx_start;
  assign w_roll       = (r_tcnt == r_period);
  assign w_period_cap = (bit_period == '0) ? ONE : bit_period;

  // r_last holds size-1 so the index compare needs no extra bit
  always_comb begin
    w_last_cap = 3'd7;
    case (data_size)
      4'd5:    w_last_cap = 3'd4;
      4'd6:    w_last_cap = 3'd5;
      4'd7:    w_last_cap = 3'd6;
      default: w_last_cap = 3'd7;
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  logic w_parity;
  always_comb begin
    w_parity = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) <= r_last) w_parity = w_parity ^ r_data[i];
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_tcnt  = r_tcnt;
    w_next_idx   = r_idx;
    if (r_state == IDLE) begin
      if (tx_start) begin
        w_next_state = START;
        w_next_tcnt  = ONE;
        w_next_idx   = '0;
      end
    end else if (!w_roll) begin
      w_next_tcnt = r_tcnt + ONE;
    end else begin
      w_next_tcnt = ONE;
      case (r_state)
        START: begin
          w_next_state = DATA;
          w_next_idx   = '0;
        end
        DATA: begin
          if (r_idx == r_last) begin
`ifdef SERIAL_TX_PARITY_EN
            w_next_state = PARITY;
`else
            w_next_state = STOP;
`endif
          end else begin
            w_next_idx = r_idx + 3'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: w_next_state = STOP;
`endif
        STOP: begin
          w_next_state = IDLE;
          w_next_tcnt  = '0;
        end
        default: begin
          w_next_state = IDLE;
          w_next_tcnt  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they align with the state
  always_comb begin
    w_line = 1'b1;
    case (w_next_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_data[w_next_idx];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  w_line = w_parity;
`endif
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_last     <= '0;
      r_period   <= '0;
      r_tcnt     <= '0;
      r_idx      <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data   <= tx_data;
        r_last   <= w_last_cap;
        r_period <= w_period_cap;
      end
      r_state    <= w_next_state;
      r_tcnt     <= w_next_tcnt;
      r_idx      <= w_next_idx;
      serial_out <= w_line;
      tx_busy    <= (w_next_state != IDLE);
      tx_done    <= (w_next_state == STOP) && (w_next_tcnt == r_period);
    end
  end

endmodule
